// File: rtl/mips_run_pkg.sv
// rtl/mips_run_pkg.sv - shared types, constants and helpers for the run/dump controller
// Contents:
//   run_state_t     controller state encoding
//   DEF_DUMP_ADDRS  default packed dump address list (entry 0 in the low bits)
//   dump_addr_at()  extracts one entry from a packed address list
package mips_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_RUN      = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_OUT = 3'd4,
    S_DONE     = 3'd5
  } run_state_t;

  localparam logic [23:0] DEF_DUMP_ADDRS = {8'd16, 8'd4, 8'd1};

  // Widest list / address the helper can handle; callers zero-extend into it.
  localparam int MAX_LIST_W = 1024;
  localparam int MAX_ADDR_W = 32;

  function automatic logic [MAX_ADDR_W-1:0] dump_addr_at(
    input logic [MAX_LIST_W-1:0] list,
    input int                    addr_w,
    input int                    i
  );
    logic [MAX_LIST_W-1:0] shifted;
    logic [MAX_ADDR_W-1:0] mask;
    shifted = list >> (i * addr_w);
    // For addr_w == MAX_ADDR_W the shift wraps to 0 and the subtract gives all-ones.
    mask = (MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1);
    return shifted[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/mips_run_controller_if.sv
// rtl/mips_run_controller_if.sv - data-memory read port and dump stream bundle
// Signals:
//   dmem_rd_en / dmem_rd_addr  read request from the controller
//   dmem_rd_data               read data from the data memory
//   dump_valid / dump_ready    dump stream handshake
//   dump_addr / dump_data      dump word and the address it came from
// Modports: master = controller side, slave = memory/consumer side.
interface mips_run_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              dmem_rd_en;
  logic [ADDR_W-1:0] dmem_rd_addr;
  logic [DATA_W-1:0] dmem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dmem_rd_en, dmem_rd_addr,
    input  dmem_rd_data,
    output dump_valid, dump_addr, dump_data,
    input  dump_ready
  );

  modport slave (
    input  dmem_rd_en, dmem_rd_addr,
    output dmem_rd_data,
    input  dump_valid, dump_addr, dump_data,
    output dump_ready
  );
endinterface

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating run-cycle counter with timeout match
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   clr          zero the count (wins over en)
//   en           count this cycle; holds at all-ones
//   cnt          current count
//   term         cnt == TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES == 0)
module run_cycle_counter #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);
  localparam bit             TERM_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = TERM_EN && (cnt == TERM_VAL);
endmodule

// File: rtl/mips_run_controller.sv
// rtl/mips_run_controller.sv - CPU run controller and post-run data-memory dump engine
// Ports:
//   clk, pcclr   clock, synchronous active-low reset
//   start        begin a run (accepted in IDLE or DONE only)
//   cpu_fin      CPU finished flag, looked at only while running
//   cpu_rst_n    registered active-low reset to the CPU
//   bus          data-memory read port and dump stream (master side)
//   cycle_cnt    cycles spent running, frozen after the run
//   timeout      run ended by the cycle limit instead of cpu_fin
//   done         run and dump complete
module mips_run_controller
  import mips_run_pkg::*;
#(
  parameter int                         DATA_W         = 32,
  parameter int                         ADDR_W         = 8,
  parameter int                         NUM_DUMP       = 3,
  parameter logic [NUM_DUMP*ADDR_W-1:0] DUMP_ADDRS     = DEF_DUMP_ADDRS,
  parameter int                         CNT_W          = 32,
  parameter int                         TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    pcclr,
  input  logic                    start,
  input  logic                    cpu_fin,
  output logic                    cpu_rst_n,
  mips_run_controller_if.master   bus,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    timeout,
  output logic                    done
);
  localparam int               IDX_W    = (NUM_DUMP > 1) ? $clog2(NUM_DUMP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DUMP - 1);

  run_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_term;
  logic              start_ok;

  assign cur_addr  = ADDR_W'(dump_addr_at(MAX_LIST_W'(DUMP_ADDRS), ADDR_W, int'(idx)));
  assign next_addr = ADDR_W'(dump_addr_at(MAX_LIST_W'(DUMP_ADDRS), ADDR_W, int'(idx) + 1));

  // Counter is zeroed the moment a start is accepted, so it already reads 0 in RST.
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign cnt_clr  = start_ok;
  assign cnt_en   = (state == S_RUN);

  run_cycle_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .resetn (pcclr),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cycle_cnt),
    .term   (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (!pcclr) begin
      state            <= S_IDLE;
      idx              <= '0;
      cpu_rst_n        <= 1'b0;
      bus.dmem_rd_en   <= 1'b0;
      bus.dmem_rd_addr <= '0;
      bus.dump_valid   <= 1'b0;
      bus.dump_addr    <= '0;
      bus.dump_data    <= '0;
      timeout          <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state     <= S_RST;
            cpu_rst_n <= 1'b0;
            idx       <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
          end
        end
        S_RST: begin
          state     <= S_RUN;
          cpu_rst_n <= 1'b1;
        end
        S_RUN: begin
          // cpu_fin is checked first so a same-cycle timeout match leaves timeout low.
          if (cpu_fin || cnt_term) begin
            state            <= S_DUMP_RD;
            timeout          <= !cpu_fin;
            bus.dmem_rd_en   <= 1'b1;
            bus.dmem_rd_addr <= cur_addr;
          end
        end
        S_DUMP_RD: begin
          state          <= S_DUMP_OUT;
          bus.dmem_rd_en <= 1'b0;
          bus.dump_valid <= 1'b1;
          bus.dump_addr  <= cur_addr;
          bus.dump_data  <= bus.dmem_rd_data;
        end
        S_DUMP_OUT: begin
          // dump_valid is always high here, so ready alone completes the beat.
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              idx              <= idx + 1'b1;
              state            <= S_DUMP_RD;
              bus.dmem_rd_en   <= 1'b1;
              bus.dmem_rd_addr <= next_addr;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
